button_conditioner: RTL
=======================

Name: button_conditioner

Overview:
Upstream input stage for the paddle mover. Takes raw, asynchronous, active-low push-button levels from the board. Each channel is synchronised and debounced, and the block produces clean active-low levels that drive the paddle mover's 2-bit button input directly, with up on bit 1 and down on bit 0. It also emits a one-cycle press pulse per channel for future menu and serve logic.

Parameters:
NUM_KEYS, 2, number of independent button channels (bit 1 = up, bit 0 = down for paddle use).
SYNC_STAGES, 2, flip-flop depth of the input synchroniser; must be 2 or more.
DEBOUNCE_CYCLES, 500000, consecutive stable synchronised samples needed to accept a level change (10 ms at 50 MHz); must be 1 or more.

Ports:
clock  input  1  system clock, 50 MHz.
reset  input  1  asynchronous, active-low reset; 0 resets the block.
key_n  input  NUM_KEYS  raw button levels, active-low, asynchronous to clock.
button  output  NUM_KEYS  debounced levels, active-low; connects to the paddle mover's button port.
pressed  output  NUM_KEYS  one-cycle high pulse when a channel's debounced state goes from released to pressed.

Behaviour:
- Reset (reset=0, asynchronous):
  - all synchroniser flops set to 1;
  - button = all 1s; pressed = all 0s;
  - every counter = 0; every channel FSM = RELEASED.
- Synchroniser: key_n[i] passes through SYNC_STAGES flops to give s[i]. Flops are plain registers, with no logic between stages.
- Per-channel FSM has states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT. cnt is a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - RELEASED: if s=0, go to PRESS_WAIT and set cnt=1; otherwise stay.
  - PRESS_WAIT:
    - if s=1, go to RELEASED and set cnt=0; button is unchanged, no pulse.
    - else if cnt==DEBOUNCE_CYCLES, go to PRESSED, clear button[i] to 0, and set pressed[i]=1 for exactly one cycle.
    - else cnt increments.
  - PRESSED: if s=1, go to RELEASE_WAIT and set cnt=1; otherwise stay.
  - RELEASE_WAIT:
    - if s=0, go back to PRESSED and set cnt=0.
    - else if cnt==DEBOUNCE_CYCLES, go to RELEASED and set button[i] to 1; no pulse on release.
    - else cnt increments.
- Latency: with key_n stable, button changes exactly SYNC_STAGES+DEBOUNCE_CYCLES+1 rising edges after the first edge that samples the new raw level. pressed asserts on the same edge that button falls.
- Glitch rejection: any bounce shorter than DEBOUNCE_CYCLES synchronised samples produces no change on button or pressed.
- Registers: all outputs are registered. button and pressed come straight from flops, with no combinational path from key_n.
- Counters saturate by construction, because the FSM leaves the WAIT state at DEBOUNCE_CYCLES; there is no wrap-around.
- Independence: channels are fully independent, and simultaneous events on several channels are each handled as if alone (unless the optional feature is enabled).
- Reset mid-operation: an asserted reset in any state abandons the pending count. button returns to 1 immediately (asynchronously), and pressed clears.

Optional Feature:
Macro BUTTON_CONFLICT_MASK_EN.
- Defined:
  - when the debounced channels 1 and 0 are both pressed, button[1:0] is forced to 2'b11 (no movement), registered with one extra cycle of latency on bits [1:0] only;
  - pressed pulses are unaffected, and other channels are unaffected;
  - requires NUM_KEYS of 2 or more.
- Undefined: button mirrors the debounced state directly and both-pressed passes through as 2'b00.

Decomposition:
- Shared package pong_input_pkg holds:
  - the FSM state encoding (2-bit localparams ST_RELEASED=0, ST_PRESS_WAIT=1, ST_PRESSED=2, ST_RELEASE_WAIT=3);
  - the default DEBOUNCE_CYCLES for 50 MHz;
  - the paddle bit indices KEY_UP=1 and KEY_DOWN=0.
- One sub-module, button_debounce_channel, contains the synchroniser, counter and FSM for a single key, with outputs level_n and press_pulse.
- The top level instantiates button_debounce_channel NUM_KEYS times in a generate loop and holds the optional conflict mask.

Test Plan:
All scenarios use SYNC_STAGES=2 and DEBOUNCE_CYCLES=8.
1. Reset: hold reset=0 with key_n=2'b00 for 3 cycles -> button=2'b11 and pressed=2'b00 throughout. Release reset -> button[1] falls exactly 11 edges later, and pressed[1] is high for exactly that one cycle.
2. Clean press and release: drive key_n[1]=0 at a clock edge and hold it for 40 cycles -> button[1]=0 after 11 edges with one pressed[1] pulse. Then drive key_n[1]=1 -> button[1]=1 after 11 edges, with no pulse.
3. Bounce rejection: toggle key_n[0] low for 5 cycles then high, repeated 4 times -> button[0] stays 1 and pressed[0] never asserts. A following solid low of 12 cycles -> a single press is accepted.
4. Mid-count reset: key_n[1]=0 for 6 cycles, then reset=0 for 1 cycle while key_n[1] stays 0 -> button[1] stays 1 and the count restarts, so button[1] falls 11 edges after reset is deasserted.
5. Simultaneous keys: key_n 2'b11 to 2'b00 on one edge ->
   - without the macro: button=2'b00 after 11 edges, with both pressed bits pulsing together;
   - with BUTTON_CONFLICT_MASK_EN: button stays 2'b11, while both pressed bits still pulse.
6. Drive MovePaddle through this block, holding up for a debounced 20 cycles -> paddleYValue decreases from 240 and never goes below 185.

Source files
------------

// File: rtl/pong_input_pkg.sv
// rtl/pong_input_pkg.sv - shared constants for the pong button input stage
//
// Purpose: FSM state encoding for the per-key debouncer, the default
// debounce length for a 50 MHz clock, and the paddle bit indices.
// Ports: none (package).

package pong_input_pkg;

  localparam logic [1:0] ST_RELEASED     = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_PRESSED      = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  // 10 ms at 50 MHz
  localparam int DEBOUNCE_CYCLES_50MHZ = 500000;

  localparam int KEY_UP   = 1;
  localparam int KEY_DOWN = 0;

endpackage

// File: rtl/button_debounce_channel.sv
// rtl/button_debounce_channel.sv - synchroniser, counter and FSM for one key
//
// Purpose: synchronise one raw active-low key, accept a level change only
// after DEBOUNCE_CYCLES consecutive stable samples, and pulse on press.
// Ports:
//   clock       in   system clock
//   reset       in   asynchronous active-low reset
//   key_n       in   raw key level, active-low, asynchronous
//   level_n     out  debounced level, active-low, registered
//   press_pulse out  one-cycle pulse on released->pressed, registered

module button_debounce_channel
  import pong_input_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic level_n,
  output logic press_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [1:0]             state;
  logic [CW-1:0]          cnt;

  // Plain flop chain; reset to 1 so a reset looks like "released".
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync <= '1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], key_n};
    end
  end

  assign s = sync[SYNC_STAGES-1];

  // cnt holds the number of consecutive stable samples seen in a WAIT state;
  // the FSM leaves the WAIT state when it reaches CNT_MAX, so it never wraps.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_RELEASED;
      cnt         <= '0;
      level_n     <= 1'b1;
      press_pulse <= 1'b0;
    end else begin
      press_pulse <= 1'b0;
      case (state)
        ST_RELEASED: begin
          if (!s) begin
            state <= ST_PRESS_WAIT;
            cnt   <= CW'(1);
          end
        end
        ST_PRESS_WAIT: begin
          if (s) begin
            state <= ST_RELEASED;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state       <= ST_PRESSED;
            cnt         <= '0;
            level_n     <= 1'b0;
            press_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_PRESSED: begin
          if (s) begin
            state <= ST_RELEASE_WAIT;
            cnt   <= CW'(1);
          end
        end
        ST_RELEASE_WAIT: begin
          if (!s) begin
            state <= ST_PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state   <= ST_RELEASED;
            cnt     <= '0;
            level_n <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= ST_RELEASED;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - debounced active-low button inputs for the paddle mover
//
// Purpose: one debounce channel per key; button drives the paddle mover
// (bit 1 = up, bit 0 = down), pressed gives a one-cycle press pulse.
// Optional macro BUTTON_CONFLICT_MASK_EN: when up and down are both pressed,
// button[1:0] reads 2'b11, through one extra register stage on bits [1:0].
// Ports:
//   clock    in   system clock, 50 MHz
//   reset    in   asynchronous active-low reset
//   key_n    in   raw key levels [NUM_KEYS], active-low, asynchronous
//   button   out  debounced levels [NUM_KEYS], active-low
//   pressed  out  press pulses [NUM_KEYS]

module button_conditioner
  import pong_input_pkg::*;
#(
  parameter int NUM_KEYS        = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] button,
  output logic [NUM_KEYS-1:0] pressed
);

  logic [NUM_KEYS-1:0] level_n;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    button_debounce_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch (
      .clock       (clock),
      .reset       (reset),
      .key_n       (key_n[g]),
      .level_n     (level_n[g]),
      .press_pulse (pressed[g])
    );
  end

`ifdef BUTTON_CONFLICT_MASK_EN
  logic [1:0] paddle_q;

  // Up and down together means "no movement" for the paddle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      paddle_q <= 2'b11;
    end else if (!level_n[KEY_UP] && !level_n[KEY_DOWN]) begin
      paddle_q <= 2'b11;
    end else begin
      paddle_q <= level_n[1:0];
    end
  end

  assign button[1:0] = paddle_q;

  if (NUM_KEYS > 2) begin : g_upper
    assign button[NUM_KEYS-1:2] = level_n[NUM_KEYS-1:2];
  end
`else
  assign button = level_n;
`endif

endmodule
